// File: rtl/bus_drvr_fifo_if.sv
// Device/bus-side signal bundle for bus_drvr_fifo.
// The master side drives push/pop and write data; the slave side is the FIFO itself.
interface bus_drvr_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
);
    logic                       push;
    logic [pckg_sz-1:0]         D_in;
    logic                       full;
    logic                       almost_full;
    logic                       pop;
    logic [pckg_sz-1:0]         D_pop;
    logic                       pndng;
    logic [$clog2(depth+1)-1:0] count;
    logic                       ovf;
    logic                       udf;

    modport master (
        output push, D_in, pop,
        input  full, almost_full, D_pop, pndng, count, ovf, udf
    );

    modport slave (
        input  push, D_in, pop,
        output full, almost_full, D_pop, pndng, count, ovf, udf
    );
endinterface

// File: rtl/bus_drvr_fifo.sv
// First-word fall-through FIFO between a device writer and a bus arbiter reader,
// with registered head data, occupancy count and sticky overflow/underflow flags.
module bus_drvr_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int af_lvl  = 6
) (
    input logic            clk,
    input logic            reset,
    bus_drvr_fifo_if.slave bus
);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(af_lvl);

    logic [pckg_sz-1:0] mem_q [depth];

    logic [PW-1:0]      wrPtr_q, wrPtr_d;
    logic [PW-1:0]      rdPtr_q, rdPtr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [pckg_sz-1:0] dPop_q,  dPop_d;
    logic               pndng_q, pndng_d;
    logic               ovf_q,   ovf_d;
    logic               udf_q,   udf_d;
    logic               popOk;
    logic               pushOk;
    logic               emptyAfterPop;

    always_comb begin
        popOk         = bus.pop && (count_q != '0);
        // A pop on a full FIFO frees the head slot, so the same-cycle push still fits.
        pushOk        = bus.push && ((count_q != DEPTH_C) || popOk);
        emptyAfterPop = (count_q == '0) || ((count_q == CW'(1)) && popOk);

        wrPtr_d = pushOk ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = popOk  ? rdPtr_q + PW'(1) : rdPtr_q;

        count_d = count_q;
        if (pushOk && !popOk) begin
            count_d = count_q + CW'(1);
        end else if (!pushOk && popOk) begin
            count_d = count_q - CW'(1);
        end

        // Head register: bypass incoming data when the FIFO would otherwise be empty.
        dPop_d = dPop_q;
        if (count_d != '0) begin
            if (emptyAfterPop) begin
                dPop_d = bus.D_in;
            end else begin
                dPop_d = mem_q[rdPtr_d];
            end
        end

        pndng_d = (count_d != '0);
        ovf_d   = ovf_q || (bus.push && !bus.pop && (count_q == DEPTH_C));
        udf_d   = udf_q || (bus.pop && (count_q == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            dPop_q  <= '0;
            pndng_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            dPop_q  <= dPop_d;
            pndng_q <= pndng_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is left uninitialised; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (pushOk && !reset) begin
            mem_q[wrPtr_q] <= bus.D_in;
        end
    end

    assign bus.full        = (count_q == DEPTH_C);
    assign bus.almost_full = (count_q >= AF_C);
    assign bus.D_pop       = dPop_q;
    assign bus.pndng       = pndng_q;
    assign bus.count       = count_q;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;
endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Self-checking bench for bus_drvr_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_bus_drvr_fifo;
    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_drvr_fifo_if #(.pckg_sz(W), .depth(DEPTH)) bus();

    bus_drvr_fifo #(.pckg_sz(W), .depth(DEPTH), .af_lvl(AF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] modelQ [$];
    logic         ovfM;
    logic         udfM;
    logic [W-1:0] headM;

    // Expected status word: {pndng, full, almost_full, ovf, udf, count, D_pop}.
    function automatic logic [24:0] expVec();
        int n;
        n = modelQ.size();
        return {(n != 0), (n == DEPTH), (n >= AF), ovfM, udfM, 4'(n), headM};
    endfunction

    function automatic logic [24:0] dutVec();
        return {bus.pndng, bus.full, bus.almost_full, bus.ovf, bus.udf, bus.count, bus.D_pop};
    endfunction

    // Drive one cycle, advance the reference model across the edge, then settle.
    task automatic applyStimulus(input logic p, input logic q, input logic [W-1:0] d);
        int  n;
        logic doPop;
        logic doPush;
        bus.push = p;
        bus.pop  = q;
        bus.D_in = d;
        @(posedge clk);
        n = modelQ.size();
        if (q && n == 0) udfM = 1'b1;
        if (p && !q && n == DEPTH) ovfM = 1'b1;
        doPop  = q && (n > 0);
        doPush = p && ((n < DEPTH) || doPop);
        if (doPop) void'(modelQ.pop_front());
        if (doPush) modelQ.push_back(d);
        if (modelQ.size() > 0) headM = modelQ[0];
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic doReset();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.D_in = '0;
        reset    = 1'b1;
        modelQ.delete();
        ovfM  = 1'b0;
        udfM  = 1'b0;
        headM = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        total++;
        if (dutVec() !== 25'h0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h want %h", dutVec(), 25'h0);
        end
        applyStimulus(1'b0, 1'b0, 16'h1234);
        total++;
        if (dutVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL reset_idle: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_single();
        doReset();
        applyStimulus(1'b1, 1'b0, 16'hA001);
        total++;
        if ({bus.pndng, bus.count, bus.D_pop} !== {1'b1, 4'd1, 16'hA001}) begin
            bad++;
            $display("[TB] FAIL single_push: got %b/%0d/%h want 1/1/a001", bus.pndng, bus.count, bus.D_pop);
        end
        applyStimulus(1'b0, 1'b1, 16'h0);
        total++;
        if ({bus.pndng, bus.count, bus.D_pop} !== {1'b0, 4'd0, 16'hA001}) begin
            bad++;
            $display("[TB] FAIL single_pop: got %b/%0d/%h want 0/0/a001", bus.pndng, bus.count, bus.D_pop);
        end
    endtask

    task automatic test_overflow();
        doReset();
        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b0, 16'(i));
        total++;
        if ({bus.count, bus.full, bus.almost_full, bus.ovf} !== {4'd8, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL overflow_flags: got cnt=%0d f=%b af=%b ovf=%b want 8/1/1/1",
                     bus.count, bus.full, bus.almost_full, bus.ovf);
        end
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (bus.D_pop !== 16'(i) || bus.pndng !== 1'b1) begin
                bad++;
                $display("[TB] FAIL overflow_order: got %h pndng=%b want %h pndng=1", bus.D_pop, bus.pndng, 16'(i));
            end
            applyStimulus(1'b0, 1'b1, 16'h0);
        end
        total++;
        if (dutVec() !== expVec() || bus.pndng !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overflow_drained: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_full_stream();
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 16'h0100 + 16'(i));
        for (int k = 0; k < 12; k++) begin
            total++;
            if (bus.D_pop !== 16'h0100 + 16'(k) && k < DEPTH) begin
                bad++;
                $display("[TB] FAIL stream_head: got %h want %h", bus.D_pop, 16'h0100 + 16'(k));
            end else if (bus.D_pop !== 16'h0200 + 16'(k - DEPTH) && k >= DEPTH) begin
                bad++;
                $display("[TB] FAIL stream_head: got %h want %h", bus.D_pop, 16'h0200 + 16'(k - DEPTH));
            end
            applyStimulus(1'b1, 1'b1, 16'h0200 + 16'(k));
            total++;
            if ({bus.count, bus.full, bus.ovf} !== {4'd8, 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL stream_full: got cnt=%0d f=%b ovf=%b want 8/1/0", bus.count, bus.full, bus.ovf);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (bus.D_pop !== 16'h0204 + 16'(i)) begin
                bad++;
                $display("[TB] FAIL stream_drain: got %h want %h", bus.D_pop, 16'h0204 + 16'(i));
            end
            applyStimulus(1'b0, 1'b1, 16'h0);
        end
    endtask

    task automatic test_underflow();
        doReset();
        applyStimulus(1'b0, 1'b1, 16'h0);
        total++;
        if ({bus.udf, bus.count, bus.pndng} !== {1'b1, 4'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL underflow_empty: got udf=%b cnt=%0d pndng=%b want 1/0/0", bus.udf, bus.count, bus.pndng);
        end
        applyStimulus(1'b1, 1'b1, 16'hBEEF);
        total++;
        if ({bus.count, bus.D_pop, bus.pndng, bus.udf} !== {4'd1, 16'hBEEF, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL underflow_pushpop: got cnt=%0d d=%h pndng=%b udf=%b want 1/beef/1/1",
                     bus.count, bus.D_pop, bus.pndng, bus.udf);
        end
        total++;
        if (dutVec() !== expVec()) begin
            bad++;
            $display("[TB] FAIL underflow_model: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_async_reset();
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'h0300 + 16'(i));
        #2;
        reset = 1'b1;
        modelQ.delete();
        ovfM  = 1'b0;
        udfM  = 1'b0;
        headM = '0;
        #1;
        total++;
        if ({bus.pndng, bus.count, bus.D_pop} !== 21'h0) begin
            bad++;
            $display("[TB] FAIL async_reset: got pndng=%b cnt=%0d d=%h want 0/0/0000", bus.pndng, bus.count, bus.D_pop);
        end
        bus.push = 1'b1;
        bus.D_in = 16'hDEAD;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        total++;
        if (bus.count !== 4'd0) begin
            bad++;
            $display("[TB] FAIL push_in_reset: got cnt=%0d want 0", bus.count);
        end
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h0);
        total++;
        if ({bus.udf, bus.pndng, bus.count} !== {1'b1, 1'b0, 4'd0}) begin
            bad++;
            $display("[TB] FAIL post_reset_pop: got udf=%b pndng=%b cnt=%0d want 1/0/0", bus.udf, bus.pndng, bus.count);
        end
    endtask

    task automatic test_random();
        int pushPct;
        int popPct;
        doReset();
        for (int i = 0; i < 400; i++) begin
            pushPct = ((i / 50) % 2 == 0) ? 75 : 30;
            popPct  = 100 - pushPct;
            applyStimulus(($urandom_range(99) < pushPct), ($urandom_range(99) < popPct), 16'($urandom));
            total++;
            if (dutVec() !== expVec()) begin
                bad++;
                $display("[TB] FAIL random_cycle%0d: got %h want %h", i, dutVec(), expVec());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.D_in = '0;
        test_reset();
        test_single();
        test_overflow();
        test_full_stream();
        test_underflow();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
